// File: rtl/ads8332_avg_mon.sv
// Per-channel boxcar averager for ADS8332 read frames. It publishes each completed average,
// keeps a readable latest-average register per channel, and raises sticky threshold alarms.
module ads8332_avg_mon #(
  parameter int NUM_CH   = 8,
  parameter int AVG_LOG2 = 4
) (
  input  logic        spi_clk,
  input  logic        sys_rest,
  input  logic        mon_en,
  input  logic [31:0] ads_rd_parameter,
  input  logic        ads_out_valid,
  input  logic [15:0] thr_hi,
  input  logic [15:0] thr_lo,
  input  logic        alarm_clr,
  input  logic [2:0]  rd_ch,
  output logic [15:0] rd_data,
  output logic [15:0] avg_data,
  output logic [2:0]  avg_ch,
  output logic        avg_valid,
  output logic [7:0]  alarm_hi,
  output logic [7:0]  alarm_lo,
  output logic [7:0]  frame_err_cnt,
  output logic [31:0] mon_debug
);

  localparam int            CW       = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam int            AW       = 16 + AVG_LOG2;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);
  localparam logic [3:0]    NUM_CH_U = 4'(NUM_CH);
  localparam logic [7:0]    CH_MASK  = 8'((1 << NUM_CH) - 1);

  logic [AW-1:0] acc_reg    [NUM_CH];
  logic [CW-1:0] cnt_reg    [NUM_CH];
  logic [15:0]   result_reg [NUM_CH];

  logic [15:0] avg_data_reg, rd_data_reg;
  logic [2:0]  avg_ch_reg;
  logic        avg_valid_reg;
  logic [7:0]  alarm_hi_reg, alarm_lo_reg, frame_err_cnt_reg;

  logic [15:0]   sample_val;
  logic [2:0]    sample_tag;
  logic          tag_ok, accept, win_last;
  logic [AW-1:0] sel_acc, sum_next;
  logic [CW-1:0] sel_cnt;
  logic [15:0]   avg_next, rd_next;
  logic [7:0]    alarm_hi_next, alarm_lo_next;

  assign sample_val = ads_rd_parameter[31:16];
  assign sample_tag = ads_rd_parameter[15:13];
  assign tag_ok     = ({1'b0, sample_tag} < NUM_CH_U);
  assign accept     = ads_out_valid & mon_en & tag_ok;

  // Select the addressed channel's running state; the add completes in the same cycle,
  // so back-to-back frames on one channel always see the freshly written sum.
  always_comb begin
    sel_acc = '0;
    sel_cnt = '0;
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sample_tag == 3'(i)) begin
        sel_acc = acc_reg[i];
        sel_cnt = cnt_reg[i];
      end
      if (rd_ch == 3'(i)) rd_next = result_reg[i];
    end
  end

  assign sum_next = sel_acc + AW'(sample_val);
  assign win_last = (sel_cnt == CNT_LAST);
  assign avg_next = 16'(sum_next >> AVG_LOG2);

  // Alarms look at the average while it is being published; a coincident clear loses to a set.
  always_comb begin
    alarm_hi_next = alarm_clr ? 8'd0 : alarm_hi_reg;
    alarm_lo_next = alarm_clr ? 8'd0 : alarm_lo_reg;
    if (avg_valid_reg) begin
      if (avg_data_reg > thr_hi) alarm_hi_next[avg_ch_reg] = 1'b1;
      if (avg_data_reg < thr_lo) alarm_lo_next[avg_ch_reg] = 1'b1;
    end
    alarm_hi_next = alarm_hi_next & CH_MASK;
    alarm_lo_next = alarm_lo_next & CH_MASK;
  end

  always_ff @(posedge spi_clk) begin
    if (sys_rest) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_reg[i]    <= '0;
        cnt_reg[i]    <= '0;
        result_reg[i] <= '0;
      end
      avg_valid_reg     <= 1'b0;
      avg_data_reg      <= '0;
      avg_ch_reg        <= '0;
      alarm_hi_reg      <= '0;
      alarm_lo_reg      <= '0;
      frame_err_cnt_reg <= '0;
      rd_data_reg       <= '0;
    end else begin
      avg_valid_reg <= accept & win_last;
      if (accept & win_last) begin
        avg_data_reg <= avg_next;
        avg_ch_reg   <= sample_tag;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (!mon_en) begin
          acc_reg[i] <= '0;
          cnt_reg[i] <= '0;
        end else if (accept && sample_tag == 3'(i)) begin
          if (win_last) begin
            acc_reg[i]    <= '0;
            cnt_reg[i]    <= '0;
            result_reg[i] <= avg_next;
          end else begin
            acc_reg[i] <= sum_next;
            cnt_reg[i] <= cnt_reg[i] + CW'(1);
          end
        end
      end
      if (ads_out_valid && mon_en && !tag_ok && frame_err_cnt_reg != 8'hFF)
        frame_err_cnt_reg <= frame_err_cnt_reg + 8'd1;
      alarm_hi_reg <= alarm_hi_next;
      alarm_lo_reg <= alarm_lo_next;
      rd_data_reg  <= rd_next;
    end
  end

  assign avg_valid     = avg_valid_reg;
  assign avg_data      = avg_data_reg;
  assign avg_ch        = avg_ch_reg;
  assign alarm_hi      = alarm_hi_reg;
  assign alarm_lo      = alarm_lo_reg;
  assign frame_err_cnt = frame_err_cnt_reg;
  assign rd_data       = rd_data_reg;
  assign mon_debug     = {avg_valid_reg, avg_ch_reg, frame_err_cnt_reg[3:0], 8'd0, avg_data_reg};

endmodule

// File: tb/tb_ads8332_avg_mon.sv
// Bench for ads8332_avg_mon: an 8-channel, 4-sample averager plus a 4-channel pass-through
// instance, checked with directed scenarios and a randomized run against a queue-based model.
module tb_ads8332_avg_mon;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        srst = 1'b0, mon_en = 1'b0, valid_a = 1'b0, valid_b = 1'b0, alarm_clr = 1'b0;
  logic [31:0] frame = '0;
  logic [15:0] thr_hi = 16'hFFFF, thr_lo = 16'h0000;
  logic [2:0]  rd_ch = '0;

  logic [15:0] rd_data_a, avg_data_a, rd_data_b, avg_data_b;
  logic [2:0]  avg_ch_a, avg_ch_b;
  logic        avg_valid_a, avg_valid_b;
  logic [7:0]  alarm_hi_a, alarm_lo_a, err_a, alarm_hi_b, alarm_lo_b, err_b;
  logic [31:0] dbg_a, dbg_b;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [15:0] win_q [8][$];
  logic [15:0] mdl_res [8];
  logic [7:0]  mdl_hi, mdl_lo;

  always #5 clk = ~clk;

  ads8332_avg_mon #(.NUM_CH(8), .AVG_LOG2(2)) u_dut (
    .spi_clk(clk), .sys_rest(srst), .mon_en(mon_en), .ads_rd_parameter(frame),
    .ads_out_valid(valid_a), .thr_hi(thr_hi), .thr_lo(thr_lo), .alarm_clr(alarm_clr),
    .rd_ch(rd_ch), .rd_data(rd_data_a), .avg_data(avg_data_a), .avg_ch(avg_ch_a),
    .avg_valid(avg_valid_a), .alarm_hi(alarm_hi_a), .alarm_lo(alarm_lo_a),
    .frame_err_cnt(err_a), .mon_debug(dbg_a));

  ads8332_avg_mon #(.NUM_CH(4), .AVG_LOG2(0)) u_dut0 (
    .spi_clk(clk), .sys_rest(srst), .mon_en(mon_en), .ads_rd_parameter(frame),
    .ads_out_valid(valid_b), .thr_hi(thr_hi), .thr_lo(thr_lo), .alarm_clr(alarm_clr),
    .rd_ch(rd_ch), .rd_data(rd_data_b), .avg_data(avg_data_b), .avg_ch(avg_ch_b),
    .avg_valid(avg_valid_b), .alarm_hi(alarm_hi_b), .alarm_lo(alarm_lo_b),
    .frame_err_cnt(err_b), .mon_debug(dbg_b));

  function automatic logic [31:0] mk(input logic [15:0] val, input logic [2:0] tag);
    logic [12:0] junk;
    junk = 13'($urandom);
    return {val, tag, junk};
  endfunction

  // Drive one cycle of inputs; on return, outputs reflect the clock edge that consumed them.
  task automatic step(input logic va, input logic vb, input logic [31:0] fr, input logic clr);
    valid_a = va; valid_b = vb; frame = fr; alarm_clr = clr;
    @(negedge clk);
    valid_a = 1'b0; valid_b = 1'b0; alarm_clr = 1'b0;
  endtask

  task automatic do_reset();
    srst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    srst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      win_q[c].delete();
      mdl_res[c] = '0;
    end
    mdl_hi = '0;
    mdl_lo = '0;
  endtask

  // Window semantics from first principles: collect N samples per channel, emit their mean.
  task automatic model_frame(input logic v, input logic en, input logic [31:0] fr,
                             output logic ev, output logic [15:0] ed, output logic [2:0] ec);
    int unsigned s;
    int c;
    ev = 1'b0; ed = '0; ec = '0;
    if (!en) begin
      for (int k = 0; k < 8; k++) win_q[k].delete();
    end else if (v) begin
      c = int'(fr[15:13]);
      win_q[c].push_back(fr[31:16]);
      if (win_q[c].size() == N) begin
        s = 0;
        foreach (win_q[c][k]) s += win_q[c][k];
        ev = 1'b1;
        ed = 16'(s / N);
        ec = fr[15:13];
        mdl_res[c] = ed;
        if (ed > thr_hi) mdl_hi[c] = 1'b1;
        if (ed < thr_lo) mdl_lo[c] = 1'b1;
        win_q[c].delete();
      end
    end
  endtask

  task automatic test_reset();
    mon_en = 1'b1;
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (avg_valid_a !== 1'b0) begin errors++; $display("FAIL reset_avg_valid got=%b exp=0", avg_valid_a); end
    checks++; if (avg_data_a !== 16'h0) begin errors++; $display("FAIL reset_avg_data got=%h exp=0000", avg_data_a); end
    checks++; if (rd_data_a !== 16'h0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0000", rd_data_a); end
    checks++; if ({alarm_hi_a, alarm_lo_a} !== 16'h0) begin errors++; $display("FAIL reset_alarms got=%h exp=0000", {alarm_hi_a, alarm_lo_a}); end
    checks++; if (err_a !== 8'h0 || err_b !== 8'h0) begin errors++; $display("FAIL reset_err got=%h/%h exp=00/00", err_a, err_b); end
    checks++; if (dbg_a !== 32'h0) begin errors++; $display("FAIL reset_debug got=%h exp=00000000", dbg_a); end
  endtask

  task automatic test_basic_avg();
    logic [15:0] vals [4];
    vals = '{16'h1000, 16'h1002, 16'h1004, 16'h1006};
    do_reset();
    mon_en = 1'b1;
    rd_ch = 3'd3;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, mk(vals[i], 3'd3), 1'b0);
      checks++; if (avg_valid_a !== (i == 3)) begin errors++; $display("FAIL basic_valid idx=%0d got=%b exp=%b", i, avg_valid_a, i == 3); end
    end
    checks++; if (avg_data_a !== 16'h1003 || avg_ch_a !== 3'd3) begin errors++; $display("FAIL basic_avg got=%h ch%0d exp=1003 ch3", avg_data_a, avg_ch_a); end
    checks++; if (dbg_a !== 32'hB000_1003) begin errors++; $display("FAIL basic_debug got=%h exp=b0001003", dbg_a); end
    checks++; if (rd_data_a !== 16'h0) begin errors++; $display("FAIL basic_rd_old got=%h exp=0000", rd_data_a); end
    step(1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (rd_data_a !== 16'h1003) begin errors++; $display("FAIL basic_rd_new got=%h exp=1003", rd_data_a); end
    checks++; if (avg_valid_a !== 1'b0) begin errors++; $display("FAIL basic_strobe_len got=%b exp=0", avg_valid_a); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, (i % 2 == 0) ? mk(16'hFFFF, 3'd0) : mk(16'h0001, 3'd1), 1'b0);
      checks++; if (avg_valid_a !== (i >= 6)) begin errors++; $display("FAIL b2b_valid idx=%0d got=%b exp=%b", i, avg_valid_a, i >= 6); end
      if (i == 6) begin
        checks++; if (avg_data_a !== 16'hFFFF || avg_ch_a !== 3'd0) begin errors++; $display("FAIL b2b_ch0 got=%h ch%0d exp=ffff ch0", avg_data_a, avg_ch_a); end
      end
      if (i == 7) begin
        checks++; if (avg_data_a !== 16'h0001 || avg_ch_a !== 3'd1) begin errors++; $display("FAIL b2b_ch1 got=%h ch%0d exp=0001 ch1", avg_data_a, avg_ch_a); end
      end
    end
  endtask

  task automatic test_alarms();
    do_reset();
    mon_en = 1'b1;
    thr_hi = 16'h8000;
    thr_lo = 16'h0100;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, mk(16'h9000, 3'd2), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, mk(16'h0100, 3'd5), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, mk(16'h0010, 3'd6), 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (alarm_hi_a !== 8'h04) begin errors++; $display("FAIL alarm_hi_set got=%h exp=04", alarm_hi_a); end
    checks++; if (alarm_lo_a !== 8'h40) begin errors++; $display("FAIL alarm_lo_set got=%h exp=40", alarm_lo_a); end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, mk(16'h9000, 3'd2), 1'b0);
    checks++; if (avg_valid_a !== 1'b1) begin errors++; $display("FAIL alarm_reavg got=%b exp=1", avg_valid_a); end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (alarm_hi_a !== 8'h04) begin errors++; $display("FAIL alarm_clr_hi got=%h exp=04", alarm_hi_a); end
    checks++; if (alarm_lo_a !== 8'h00) begin errors++; $display("FAIL alarm_clr_lo got=%h exp=00", alarm_lo_a); end
    thr_hi = 16'hFFFF;
    thr_lo = 16'h0000;
  endtask

  task automatic test_err_sat();
    do_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1, mk(16'($urandom), 3'd6), 1'b0);
      checks++; if (avg_valid_b !== 1'b0) begin errors++; $display("FAIL err_no_avg idx=%0d got=%b exp=0", i, avg_valid_b); end
      if (i == 9) begin
        checks++; if (err_b !== 8'd10) begin errors++; $display("FAIL err_count got=%0d exp=10", err_b); end
      end
    end
    checks++; if (err_b !== 8'd255) begin errors++; $display("FAIL err_saturate got=%0d exp=255", err_b); end
    checks++; if (dbg_b[27:24] !== 4'hF) begin errors++; $display("FAIL err_debug got=%h exp=f", dbg_b[27:24]); end
    checks++; if (err_a !== 8'd0) begin errors++; $display("FAIL err_other_inst got=%0d exp=0", err_a); end
  endtask

  task automatic test_passthru();
    logic [15:0] v;
    logic [2:0]  t;
    do_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v = 16'($urandom);
      t = 3'($urandom_range(0, 3));
      step(1'b0, 1'b1, mk(v, t), 1'b0);
      checks++; if (avg_valid_b !== 1'b1 || avg_data_b !== v || avg_ch_b !== t) begin
        errors++; $display("FAIL passthru got=%b %h ch%0d exp=1 %h ch%0d", avg_valid_b, avg_data_b, avg_ch_b, v, t);
      end
    end
    mon_en = 1'b0;
    step(1'b0, 1'b1, mk(16'h1234, 3'd1), 1'b0);
    checks++; if (avg_valid_b !== 1'b0) begin errors++; $display("FAIL passthru_disabled got=%b exp=0", avg_valid_b); end
    mon_en = 1'b1;
  endtask

  task automatic test_mon_en();
    do_reset();
    mon_en = 1'b1;
    rd_ch = 3'd1;
    step(1'b1, 1'b0, mk(16'h0200, 3'd1), 1'b0);
    step(1'b1, 1'b0, mk(16'h0200, 3'd1), 1'b0);
    mon_en = 1'b0;
    step(1'b0, 1'b0, 32'h0, 1'b0);
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, mk(16'h0040, 3'd1), 1'b0);
      checks++; if (avg_valid_a !== (i == 3)) begin errors++; $display("FAIL en_window idx=%0d got=%b exp=%b", i, avg_valid_a, i == 3); end
    end
    checks++; if (avg_data_a !== 16'h0040) begin errors++; $display("FAIL en_avg got=%h exp=0040", avg_data_a); end
    step(1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (rd_data_a !== 16'h0040) begin errors++; $display("FAIL en_rd got=%h exp=0040", rd_data_a); end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, mk(16'h0040, 3'd1), 1'b0);
    do_reset();
    checks++; if (avg_data_a !== 16'h0 || rd_data_a !== 16'h0 || avg_valid_a !== 1'b0) begin
      errors++; $display("FAIL rst_mid got=%h %h %b exp=0000 0000 0", avg_data_a, rd_data_a, avg_valid_a);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, mk(16'h0100, 3'd1), 1'b0);
      checks++; if (avg_valid_a !== (i == 3)) begin errors++; $display("FAIL rst_window idx=%0d got=%b exp=%b", i, avg_valid_a, i == 3); end
    end
    checks++; if (avg_data_a !== 16'h0100) begin errors++; $display("FAIL rst_avg got=%h exp=0100", avg_data_a); end
  endtask

  task automatic test_random();
    logic        v, ev;
    logic [15:0] ed;
    logic [2:0]  ec;
    logic [31:0] fr;
    thr_hi = 16'($urandom_range(16'h9000, 16'hB000));
    thr_lo = 16'($urandom_range(16'h5000, 16'h7000));
    do_reset();
    for (int i = 0; i < 600; i++) begin
      mon_en = ($urandom_range(0, 99) != 0);
      v = ($urandom_range(0, 9) < 7);
      fr = mk(16'($urandom), 3'($urandom));
      model_frame(v, mon_en, fr, ev, ed, ec);
      step(v, 1'b0, fr, 1'b0);
      checks++; if (avg_valid_a !== ev) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, avg_valid_a, ev); end
      if (ev) begin
        checks++; if (avg_data_a !== ed || avg_ch_a !== ec) begin errors++; $display("FAIL rnd_avg cyc=%0d got=%h ch%0d exp=%h ch%0d", i, avg_data_a, avg_ch_a, ed, ec); end
      end
    end
    mon_en = 1'b1;
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (alarm_hi_a !== mdl_hi || alarm_lo_a !== mdl_lo) begin
      errors++; $display("FAIL rnd_alarms got=%h/%h exp=%h/%h", alarm_hi_a, alarm_lo_a, mdl_hi, mdl_lo);
    end
    checks++; if (err_a !== 8'd0) begin errors++; $display("FAIL rnd_err got=%0d exp=0", err_a); end
    for (int c = 0; c < 8; c++) begin
      rd_ch = 3'(c);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if (rd_data_a !== mdl_res[c]) begin errors++; $display("FAIL rnd_rd ch%0d got=%h exp=%h", c, rd_data_a, mdl_res[c]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_avg();
    test_back_to_back();
    test_alarms();
    test_err_sat();
    test_passthru();
    test_mon_en();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
